// File: rtl/rv32_pkg.sv
// ============================================================================
//  Module      : rv32_pkg
//  Description : RV32I opcode and ALU-op encodings, ID/EX control bundle and
//                register-usage decode helpers.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package rv32_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_OR   = 4'd7;
    localparam logic [3:0] ALU_AND  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic [2:0] funct3;
    } ctrl_t;

    function automatic logic uses_rs1(input logic [6:0] opcode);
        return !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_R || opcode == OP_STORE || opcode == OP_BRANCH);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// ============================================================================
//  Module      : hazard_detect
//  Description : Combinational load-use detection of the ID instruction
//                against the load currently held in EX.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_detect
    import rv32_pkg::*;
(
    input  logic       id_valid,
    input  logic [6:0] id_opcode,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    output logic       load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    always_comb begin
        w_rs1_hit = uses_rs1(id_opcode) && (id_rs1 == ex_rd);
        w_rs2_hit = uses_rs2(id_opcode) && (id_rs2 == ex_rd);
        // x0 is never a real producer, so a load to x0 cannot create a hazard
        load_use  = ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid
                    && (w_rs1_hit || w_rs2_hit);
    end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register with load-use bubble insertion,
//                flush/hold priority and a saturating bubble counter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_stage
    import rv32_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [6:0]       id_opcode,
    input  logic [3:0]       id_alu_op,
    input  logic             id_alu_src,
    input  logic             id_mem_to_reg,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_branch,
    input  logic             id_jal,
    input  logic             id_jalr,
    input  logic [2:0]       id_funct3,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             flush,
    input  logic             ex_hold,
    output logic             stall_if_id,
    output logic             ex_valid,
    output logic [3:0]       ex_alu_op,
    output logic             ex_alu_src,
    output logic             ex_mem_to_reg,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_branch,
    output logic             ex_jal,
    output logic             ex_jalr,
    output logic [2:0]       ex_funct3,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [CNT_W-1:0] bubble_cnt
);

    ctrl_t             w_id_ctrl;
    ctrl_t             ctrl_d,     ctrl_q;
    logic              valid_d,    valid_q;
    logic [XLEN-1:0]   pc_d,       pc_q;
    logic [XLEN-1:0]   rs1_data_d, rs1_data_q;
    logic [XLEN-1:0]   rs2_data_d, rs2_data_q;
    logic [XLEN-1:0]   imm_d,      imm_q;
    logic [4:0]        rs1_d,      rs1_q;
    logic [4:0]        rs2_d,      rs2_q;
    logic [4:0]        rd_d,       rd_q;
    logic [CNT_W-1:0]  cnt_d,      cnt_q;
    logic              w_load_use;

    hazard_detect u_hazard_detect (
        .id_valid    (id_valid),
        .id_opcode   (id_opcode),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_valid    (valid_q),
        .ex_mem_read (ctrl_q.mem_read),
        .ex_rd       (rd_q),
        .load_use    (w_load_use)
    );

    assign stall_if_id = (w_load_use && !flush) || ex_hold;

    always_comb begin
        w_id_ctrl = '{alu_op:     id_alu_op,
                      alu_src:    id_alu_src,
                      mem_to_reg: id_mem_to_reg,
                      reg_write:  id_reg_write,
                      mem_read:   id_mem_read,
                      mem_write:  id_mem_write,
                      branch:     id_branch,
                      jal:        id_jal,
                      jalr:       id_jalr,
                      funct3:     id_funct3};

        valid_d    = valid_q;
        ctrl_d     = ctrl_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;

        // Flush outranks hold so a killed instruction never lingers in EX
        if (flush || (!ex_hold && w_load_use)) begin
            valid_d    = 1'b0;
            ctrl_d     = '0;
            pc_d       = '0;
            rs1_data_d = '0;
            rs2_data_d = '0;
            imm_d      = '0;
            rs1_d      = '0;
            rs2_d      = '0;
            rd_d       = '0;
            if (!flush && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (!ex_hold) begin
            valid_d    = id_valid;
            ctrl_d     = id_valid ? w_id_ctrl : '0;
            pc_d       = id_pc;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = id_imm;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rd_d       = id_rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_alu_op     = ctrl_q.alu_op;
    assign ex_alu_src    = ctrl_q.alu_src;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_branch     = ctrl_q.branch;
    assign ex_jal        = ctrl_q.jal;
    assign ex_jalr       = ctrl_q.jalr;
    assign ex_funct3     = ctrl_q.funct3;
    assign ex_pc         = pc_q;
    assign ex_rs1_data   = rs1_data_q;
    assign ex_rs2_data   = rs2_data_q;
    assign ex_imm        = imm_q;
    assign ex_rs1        = rs1_q;
    assign ex_rs2        = rs2_q;
    assign ex_rd         = rd_q;
    assign bubble_cnt    = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Self-checking bench for id_ex_stage (vector table + queue).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;
    import rv32_pkg::*;

    localparam int XLEN  = 32;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst;
    logic             id_valid;
    logic [6:0]       id_opcode;
    logic [3:0]       id_alu_op;
    logic             id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read;
    logic             id_mem_write, id_branch, id_jal, id_jalr;
    logic [2:0]       id_funct3;
    logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic             flush, ex_hold;
    logic             stall_if_id, ex_valid;
    logic [3:0]       ex_alu_op;
    logic             ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read;
    logic             ex_mem_write, ex_branch, ex_jal, ex_jalr;
    logic [2:0]       ex_funct3;
    logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic [CNT_W-1:0] bubble_cnt;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_mem_to_reg(id_mem_to_reg),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_branch(id_branch), .id_jal(id_jal), .id_jalr(id_jalr), .id_funct3(id_funct3),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush), .ex_hold(ex_hold),
        .stall_if_id(stall_if_id), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
        .ex_alu_src(ex_alu_src), .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
        .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_funct3(ex_funct3), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [6:0]  op;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mr;
        logic [31:0] imm;
        logic        fl, hd;
        logic        e_stall;
        logic        e_v;
        logic [4:0]  e_rd, e_rs1;
        logic        e_rw, e_mr;
        logic [31:0] e_imm;
        int          e_cnt;
        logic        e_bub;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t mk(logic v, logic [6:0] op, logic [4:0] rs1, logic [4:0] rs2,
                                logic [4:0] rd, logic rw, logic mr, logic [31:0] imm,
                                logic fl, logic hd, logic es, logic ev, logic [4:0] erd,
                                logic [4:0] ers1, logic erw, logic emr, logic [31:0] eimm,
                                int ecnt, logic eb);
        vec_t t;
        t.v = v; t.op = op; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.rw = rw; t.mr = mr;
        t.imm = imm; t.fl = fl; t.hd = hd; t.e_stall = es; t.e_v = ev; t.e_rd = erd;
        t.e_rs1 = ers1; t.e_rw = erw; t.e_mr = emr; t.e_imm = eimm; t.e_cnt = ecnt;
        t.e_bub = eb;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic any_ex_nonzero();
        return |{ex_valid, ex_alu_op, ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read,
                 ex_mem_write, ex_branch, ex_jal, ex_jalr, ex_funct3, ex_pc, ex_rs1_data,
                 ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd};
    endfunction

    task automatic drive(input vec_t t);
        id_valid      = t.v;
        id_opcode     = t.op;
        id_rs1        = t.rs1;
        id_rs2        = t.rs2;
        id_rd         = t.rd;
        id_reg_write  = t.rw;
        id_mem_read   = t.mr;
        id_mem_to_reg = t.mr;
        id_imm        = t.imm;
        flush         = t.fl;
        ex_hold       = t.hd;
        id_alu_op     = ALU_ADD;
        id_alu_src    = 1'b1;
        id_funct3     = 3'd2;
        id_pc         = 32'h0000_1000 + {27'd0, t.rd};
        id_rs1_data   = 32'hAAAA_0001;
        id_rs2_data   = 32'h5555_0002;
    endtask

    // Apply one vector: stall is checked against the current EX contents,
    // the post-edge expectation travels through the scoreboard queue.
    task automatic apply(input vec_t t, input int idx);
        vec_t e;
        drive(t);
        #1;
        chk($sformatf("stall[%0d]", idx), {63'd0, stall_if_id}, {63'd0, t.e_stall});
        sb.push_back(t);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk($sformatf("ex_valid[%0d]", idx), {63'd0, ex_valid}, {63'd0, e.e_v});
        chk($sformatf("ex_rd[%0d]", idx), {59'd0, ex_rd}, {59'd0, e.e_rd});
        chk($sformatf("ex_rs1[%0d]", idx), {59'd0, ex_rs1}, {59'd0, e.e_rs1});
        chk($sformatf("ex_reg_write[%0d]", idx), {63'd0, ex_reg_write}, {63'd0, e.e_rw});
        chk($sformatf("ex_mem_read[%0d]", idx), {63'd0, ex_mem_read}, {63'd0, e.e_mr});
        chk($sformatf("ex_imm[%0d]", idx), {32'd0, ex_imm}, {32'd0, e.e_imm});
        chk($sformatf("bubble_cnt[%0d]", idx), {61'd0, bubble_cnt}, 64'(e.e_cnt));
        if (e.e_bub)
            chk($sformatf("bubble_zero[%0d]", idx), {63'd0, any_ex_nonzero()}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t z;
        int   c;
        // inputs: v op rs1 rs2 rd rw mr imm fl hd | stall | v rd rs1 rw mr imm cnt bubble
        vecs.push_back(mk(1, OP_IMM,    0,  0,  5, 1, 0, 7,        0, 0, 0, 1,  5,  0, 1, 0, 7,        0, 0));
        vecs.push_back(mk(1, OP_LOAD,   5,  0,  6, 1, 1, 0,        0, 0, 0, 1,  6,  5, 1, 1, 0,        0, 0));
        vecs.push_back(mk(1, OP_R,      6,  1,  7, 1, 0, 0,        0, 0, 1, 0,  0,  0, 0, 0, 0,        1, 1));
        vecs.push_back(mk(1, OP_R,      6,  1,  7, 1, 0, 0,        0, 0, 0, 1,  7,  6, 1, 0, 0,        1, 0));
        vecs.push_back(mk(1, OP_LOAD,   1,  0,  0, 1, 1, 4,        0, 0, 0, 1,  0,  1, 1, 1, 4,        1, 0));
        vecs.push_back(mk(1, OP_R,      0,  0,  8, 1, 0, 0,        0, 0, 0, 1,  8,  0, 1, 0, 0,        1, 0));
        vecs.push_back(mk(1, OP_LOAD,   2,  0,  6, 1, 1, 8,        0, 0, 0, 1,  6,  2, 1, 1, 8,        1, 0));
        vecs.push_back(mk(1, OP_LUI,    6,  6,  6, 1, 0, 32'h1000, 0, 0, 0, 1,  6,  6, 1, 0, 32'h1000, 1, 0));
        vecs.push_back(mk(1, OP_LOAD,   3,  0,  9, 1, 1, 0,        0, 0, 0, 1,  9,  3, 1, 1, 0,        1, 0));
        vecs.push_back(mk(1, OP_JAL,    9,  9,  1, 1, 0, 16,       0, 0, 0, 1,  1,  9, 1, 0, 16,       1, 0));
        vecs.push_back(mk(1, OP_LOAD,   1,  0, 10, 1, 1, 0,        0, 0, 0, 1, 10,  1, 1, 1, 0,        1, 0));
        vecs.push_back(mk(1, OP_LOAD,   2,  0, 11, 1, 1, 0,        0, 0, 0, 1, 11,  2, 1, 1, 0,        1, 0));
        vecs.push_back(mk(1, OP_STORE,  3, 11,  0, 0, 0, 12,       0, 0, 1, 0,  0,  0, 0, 0, 0,        2, 1));
        vecs.push_back(mk(1, OP_STORE,  3, 11,  0, 0, 0, 12,       0, 0, 0, 1,  0,  3, 0, 0, 12,       2, 0));
        vecs.push_back(mk(0, OP_LOAD,   4,  0,  3, 1, 1, 5,        0, 0, 0, 0,  3,  4, 0, 0, 5,        2, 0));
        vecs.push_back(mk(1, OP_LOAD,   0,  0, 12, 1, 1, 0,        0, 0, 0, 1, 12,  0, 1, 1, 0,        2, 0));
        vecs.push_back(mk(1, OP_R,     12,  0, 13, 1, 0, 0,        1, 1, 1, 0,  0,  0, 0, 0, 0,        2, 1));
        vecs.push_back(mk(1, OP_IMM,    0,  0, 14, 1, 0, 3,        0, 0, 0, 1, 14,  0, 1, 0, 3,        2, 0));
        vecs.push_back(mk(1, OP_IMM,    1,  0, 15, 1, 0, 99,       0, 1, 1, 1, 14,  0, 1, 0, 3,        2, 0));
        vecs.push_back(mk(1, OP_IMM,    2,  0, 16, 1, 0, 50,       0, 1, 1, 1, 14,  0, 1, 0, 3,        2, 0));
        vecs.push_back(mk(1, OP_LOAD,   3,  0, 17, 1, 1, 0,        0, 1, 1, 1, 14,  0, 1, 0, 3,        2, 0));
        vecs.push_back(mk(1, OP_LOAD,   0,  0, 18, 1, 1, 0,        0, 0, 0, 1, 18,  0, 1, 1, 0,        2, 0));
        vecs.push_back(mk(1, OP_R,     18,  0, 19, 1, 0, 0,        0, 1, 1, 1, 18,  0, 1, 1, 0,        2, 0));
        vecs.push_back(mk(1, OP_R,     18,  0, 19, 1, 0, 0,        0, 0, 1, 0,  0,  0, 0, 0, 0,        3, 1));
        vecs.push_back(mk(1, OP_R,     18,  0, 19, 1, 0, 0,        0, 0, 0, 1, 19, 18, 1, 0, 0,        3, 0));
        // Repeated load-use pairs drive the 3-bit counter into saturation
        c = 3;
        for (int k = 0; k < 5; k++) begin
            vecs.push_back(mk(1, OP_LOAD, 0, 0, 20, 1, 1, 0, 0, 0, 0, 1, 20, 0, 1, 1, 0, c, 0));
            c = (c < 7) ? c + 1 : 7;
            vecs.push_back(mk(1, OP_R, 20, 0, 21, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, c, 1));
            vecs.push_back(mk(1, OP_R, 20, 0, 21, 1, 0, 0, 0, 0, 0, 1, 21, 20, 1, 0, 0, c, 0));
        end

        z = mk(0, 7'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(z);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ex_zero", {63'd0, any_ex_nonzero()}, 64'd0);
        chk("reset_cnt", {61'd0, bubble_cnt}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Asynchronous reset mid-cycle while a load-use stall is pending
        apply(mk(1, OP_LOAD, 0, 0, 22, 1, 1, 0, 0, 0, 0, 1, 22, 0, 1, 1, 0, 7, 0), 900);
        drive(mk(1, OP_R, 22, 0, 23, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("pre_rst_stall", {63'd0, stall_if_id}, 64'd1);
        chk("pre_rst_reg_write", {63'd0, ex_reg_write}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_ex_zero", {63'd0, any_ex_nonzero()}, 64'd0);
        chk("async_rst_cnt", {61'd0, bubble_cnt}, 64'd0);
        chk("async_rst_stall", {63'd0, stall_if_id}, 64'd0);
        @(posedge clk);
        #1;
        chk("rst_held_ex_zero", {63'd0, any_ex_nonzero()}, 64'd0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
